// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: PCSrc owner for the pipelined core.
// Bimodal 2-bit predictor looked up at fetch, branch resolution in EX,
// redirect on mispredict, and a multi-cycle front-end flush sequencer.
// Optional macro BRANCH_PRED_STATS_EN adds branch/mispredict counters.
//
// state  | meaning
// IDLE   | no flush in progress, flush=0
// FLUSH  | squashing IF/ID, flush=1, cnt counts remaining cycles minus one

module branch_pred_ctrl #(
    parameter int INDEX_W      = 4,
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic            if_is_branch,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_zero,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    output logic            pc_src,
    output logic            redirect,
    output logic            redirect_taken,
    output logic            flush
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     miss_count
`endif
);

    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         bht [ENTRIES];

    logic [INDEX_W-1:0] if_idx;
    logic [INDEX_W-1:0] ex_idx;
    logic               res;
    logic               unused_pc_bits;

    assign if_idx = if_pc[INDEX_W+1:2];
    assign ex_idx = ex_pc[INDEX_W+1:2];

    // Only the index bits of either PC take part in prediction.
    assign unused_pc_bits = ^{if_pc[PC_W-1:INDEX_W+2], if_pc[1:0],
                              ex_pc[PC_W-1:INDEX_W+2], ex_pc[1:0]};

    // Fetch-side lookup and EX-side resolution are purely combinational.
    always_comb begin
        res            = ex_valid & ex_branch;
        pred_taken     = if_valid & if_is_branch & bht[if_idx][1];
        pc_src         = res & ex_zero;
        redirect       = res & (ex_zero != ex_pred_taken);
        redirect_taken = res & ex_zero;
    end

    // Train the resolved entry with a saturating 2-bit counter.
    // The lookup above reads the old value in the same cycle (no bypass).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (res) begin
            if (ex_zero) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
        end
    end

    // Flush sequencer: a redirect (re)starts a FLUSH_CYCLES-long flush window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            flush <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        state <= FLUSH;
                        cnt   <= CNT_LOAD;
                        flush <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        cnt   <= CNT_LOAD;
                        flush <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        cnt   <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    // Free-running statistics, wrapping modulo 2**32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (res) begin
                br_count <= br_count + 32'd1;
            end
            if (redirect) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed testbench for branch_pred_ctrl (default parameters).
// Statistics checks are compiled in when BRANCH_PRED_STATS_EN is defined.

module tb_branch_pred_ctrl;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_is_branch;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_zero;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        pc_src;
    logic        redirect;
    logic        redirect_taken;
    logic        flush;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] br_count;
    logic [31:0] miss_count;
`endif

    int checks;
    int failures;

    branch_pred_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_is_branch   (if_is_branch),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_zero        (ex_zero),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .pc_src         (pc_src),
        .redirect       (redirect),
        .redirect_taken (redirect_taken),
        .flush          (flush)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .br_count       (br_count),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic b, input logic z,
                          input logic [31:0] pc, input logic p);
        ex_valid      = v;
        ex_branch     = b;
        ex_zero       = z;
        ex_pc         = pc;
        ex_pred_taken = p;
        #1;
    endtask

    task automatic clear_ex();
        set_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic look(input logic [31:0] pc);
        if_valid     = 1'b1;
        if_is_branch = 1'b1;
        if_pc        = pc;
        #1;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        if_valid      = 1'b0;
        if_is_branch  = 1'b0;
        if_pc         = '0;
        ex_valid      = 1'b0;
        ex_branch     = 1'b0;
        ex_zero       = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        look(32'h40);
        check_eq("rst_pred", pred_taken, 0);
        check_eq("rst_flush", flush, 0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_pred", pred_taken, 0);
        check_eq("post_rst_flush", flush, 0);
`ifdef BRANCH_PRED_STATS_EN
        check_eq("post_rst_br", br_count, 0);
        check_eq("post_rst_miss", miss_count, 0);
`endif

        // Mispredicted taken branch at 0x40; lookup same index sees old value.
        set_ex(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        check_eq("mp1_pc_src", pc_src, 1);
        check_eq("mp1_redirect", redirect, 1);
        check_eq("mp1_redir_taken", redirect_taken, 1);
        check_eq("mp1_no_bypass", pred_taken, 0);
        check_eq("mp1_flush_pre", flush, 0);
        tick();
        clear_ex();
        check_eq("mp1_flush_c1", flush, 1);
        check_eq("mp1_pred_10", pred_taken, 1);
        tick();
        check_eq("mp1_flush_c2", flush, 1);
        tick();
        check_eq("mp1_flush_c3", flush, 0);

        // Lookup gating.
        if_is_branch = 1'b0; #1;
        check_eq("gate_not_branch", pred_taken, 0);
        if_is_branch = 1'b1; if_valid = 1'b0; #1;
        check_eq("gate_not_valid", pred_taken, 0);
        look(32'h40);

        // Resolution gating: no res -> all outputs 0 and no training.
        set_ex(1'b0, 1'b1, 1'b1, 32'h48, 1'b0);
        check_eq("gate_exv_pc_src", pc_src, 0);
        check_eq("gate_exv_redirect", redirect, 0);
        check_eq("gate_exv_rtaken", redirect_taken, 0);
        tick();
        set_ex(1'b1, 1'b0, 1'b1, 32'h48, 1'b0);
        check_eq("gate_exb_pc_src", pc_src, 0);
        check_eq("gate_exb_redirect", redirect, 0);
        tick();
        clear_ex();
        check_eq("gate_flush", flush, 0);

        // Four correctly-predicted taken resolutions at 0x44: 01->10->11->11->11.
        for (int i = 0; i < 4; i++) begin
            set_ex(1'b1, 1'b1, 1'b1, 32'h44, 1'b1);
            check_eq("sat_redirect", redirect, 0);
            tick();
        end
        clear_ex();
        look(32'h44);
        check_eq("sat_pred", pred_taken, 1);

        // Not-taken but predicted taken: redirect to fall-through, 11->10.
        set_ex(1'b1, 1'b1, 1'b0, 32'h44, 1'b1);
        check_eq("nt_redirect", redirect, 1);
        check_eq("nt_redir_taken", redirect_taken, 0);
        check_eq("nt_pc_src", pc_src, 0);
        tick();
        clear_ex();
        check_eq("nt_flush_c1", flush, 1);
        tick();
        check_eq("nt_flush_c2", flush, 1);
        tick();
        check_eq("nt_flush_c3", flush, 0);
        check_eq("nt_pred_10", pred_taken, 1);
        // One more not-taken: 10->01, so prediction flips to not-taken.
        set_ex(1'b1, 1'b1, 1'b0, 32'h44, 1'b0);
        check_eq("nt2_redirect", redirect, 0);
        tick();
        clear_ex();
        check_eq("nt2_pred_01", pred_taken, 0);

        // Correct taken prediction at 0x48 (entry untouched by gated cycles).
        look(32'h48);
        check_eq("cp_pred_before", pred_taken, 0);
        set_ex(1'b1, 1'b1, 1'b1, 32'h48, 1'b1);
        check_eq("cp_pc_src", pc_src, 1);
        check_eq("cp_redirect", redirect, 0);
        tick();
        clear_ex();
        check_eq("cp_flush_c1", flush, 0);
        tick();
        check_eq("cp_flush_c2", flush, 0);

        // Redirect, then a second redirect on the last flush cycle.
        set_ex(1'b1, 1'b1, 1'b1, 32'h4c, 1'b0);
        check_eq("rr_redirect1", redirect, 1);
        tick();
        clear_ex();
        check_eq("rr_flush_a1", flush, 1);
        tick();
        check_eq("rr_flush_a2", flush, 1);
        set_ex(1'b1, 1'b1, 1'b0, 32'h50, 1'b1);
        check_eq("rr_redirect2", redirect, 1);
        tick();
        clear_ex();
        check_eq("rr_flush_a3", flush, 1);
        tick();
        check_eq("rr_flush_a4", flush, 1);
        tick();
        check_eq("rr_flush_a5", flush, 0);
`ifdef BRANCH_PRED_STATS_EN
        // Resolutions so far: 1 + 4 + 1 + 1 + 1 + 2 = 10; redirects: 1 + 1 + 2 = 4.
        check_eq("stats_br", br_count, 10);
        check_eq("stats_miss", miss_count, 4);
`endif

        // Reset during flush and during an in-flight taken update at 0x40 (entry=10).
        set_ex(1'b1, 1'b1, 1'b1, 32'h54, 1'b0);
        tick();
        clear_ex();
        check_eq("ra_flush_before", flush, 1);
        look(32'h40);
        check_eq("ra_pred_before", pred_taken, 1);
        set_ex(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("ra_flush_async", flush, 0);
        check_eq("ra_pred_async", pred_taken, 0);
        tick();
        clear_ex();
        rst = 1'b0;
        tick();
        check_eq("ra_pred_40", pred_taken, 0);
        look(32'h44);
        check_eq("ra_pred_44", pred_taken, 0);
        check_eq("ra_flush_after", flush, 0);
`ifdef BRANCH_PRED_STATS_EN
        check_eq("ra_br", br_count, 0);
        check_eq("ra_miss", miss_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
